// File: rtl/tff_bank_pkg.sv
// Shared definitions for the T flip-flop bank: operation-select encoding.
package tff_bank_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_UP     = 2'b10,
    MODE_DOWN   = 2'b11
  } mode_e;

endpackage

// File: rtl/tff_bank_edge.sv
// Rising-edge detector for the per-channel toggle requests.
// Only instantiated when TFF_BANK_EDGE_EN is defined.
module tff_bank_edge #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] t_rise
);

  logic [WIDTH-1:0] t_d;

  // Remember last cycle's request so a held-high t only counts once.
  always_ff @(posedge clk) begin
    if (reset) begin
      t_d <= '0;
    end else begin
      t_d <= t;
    end
  end

  assign t_rise = t & ~t_d;

endmodule

// File: rtl/tff_bank.sv
// Bank of WIDTH T flip-flops with toggle, count-up/down and parallel load.
// Define TFF_BANK_EDGE_EN to make each channel toggle once per rising edge
// of its t input instead of on every clock while t is high.
module tff_bank
  import tff_bank_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  mode_e            op;
  logic [WIDTH-1:0] t_eff;
  logic [WIDTH-1:0] q_next;
  logic             wrap_next;

  assign op = mode_e'(mode);

`ifdef TFF_BANK_EDGE_EN
  tff_bank_edge #(
    .WIDTH (WIDTH)
  ) u_edge (
    .clk    (clk),
    .reset  (reset),
    .t      (t),
    .t_rise (t_eff)
  );
`else
  assign t_eff = t;
`endif

  // Next-state selection: load beats the enabled operation, which beats hold.
  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    if (load) begin
      q_next = load_val;
    end else if (en) begin
      case (op)
        MODE_TOGGLE: q_next = q ^ t_eff;
        MODE_UP: begin
          q_next    = q + 1'b1;
          wrap_next = (q == ALL_ONES);
        end
        MODE_DOWN: begin
          q_next    = q - 1'b1;
          wrap_next = (q == '0);
        end
        default: q_next = q;
      endcase
    end
  end

  // State registers; qb is held in its own flops so it is valid from reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= INIT;
      qb   <= ~INIT;
      wrap <= 1'b0;
    end else begin
      q    <= q_next;
      qb   <= ~q_next;
      wrap <= wrap_next;
    end
  end

endmodule

// File: tb/tb_tff_bank.sv
// Self-checking bench for tff_bank: two instances (INIT=5 and INIT=0) share
// stimulus and are compared against an arithmetic reference model.
module tb_tff_bank;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] t = 4'h0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'h0;

  logic [3:0] q_a, qb_a, q_b, qb_b;
  logic       wrap_a, wrap_b;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: q value per instance as plain integers 0..15.
  int         mq [2];
  int         minit [2];
  logic       mw [2];
  logic [3:0] mtd;

  always #5 clk = ~clk;

  tff_bank #(.WIDTH(4), .INIT(4'h5)) dut_a (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .t(t),
    .load(load), .load_val(load_val), .q(q_a), .qb(qb_a), .wrap(wrap_a)
  );

  tff_bank #(.WIDTH(4), .INIT(4'h0)) dut_b (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .t(t),
    .load(load), .load_val(load_val), .q(q_b), .qb(qb_b), .wrap(wrap_b)
  );

  // Advance the reference model by one clock using the inputs about to be applied.
  task automatic modelStep();
    logic [3:0] teff;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        mq[k] = minit[k];
        mw[k] = 1'b0;
      end else if (load) begin
        mq[k] = int'(load_val);
        mw[k] = 1'b0;
      end else if (!en || mode == 2'd0) begin
        mw[k] = 1'b0;
      end else if (mode == 2'd1) begin
`ifdef TFF_BANK_EDGE_EN
        teff = t & ~mtd;
`else
        teff = t;
`endif
        mq[k] = mq[k] ^ int'(teff);
        mw[k] = 1'b0;
      end else if (mode == 2'd2) begin
        mw[k] = (mq[k] == 15);
        mq[k] = (mq[k] + 1) % 16;
      end else begin
        mw[k] = (mq[k] == 0);
        mq[k] = (mq[k] + 15) % 16;
      end
    end
    mtd = reset ? 4'h0 : t;
  endtask

  // Compare both instances against the model.
  task automatic checkOutput(input string tag);
    logic [3:0] obs_q [2];
    logic [3:0] obs_qb [2];
    logic       obs_w [2];
    obs_q[0] = q_a;  obs_qb[0] = qb_a;  obs_w[0] = wrap_a;
    obs_q[1] = q_b;  obs_qb[1] = qb_b;  obs_w[1] = wrap_b;
    for (int k = 0; k < 2; k++) begin
      assert (obs_q[k] === 4'(mq[k])) else begin
        miscompares++;
        $error("[TB] FAIL %s inst%0d q observed=%h expected=%h", tag, k, obs_q[k], 4'(mq[k]));
      end
      assert (obs_qb[k] === 4'(15 - mq[k])) else begin
        miscompares++;
        $error("[TB] FAIL %s inst%0d qb observed=%h expected=%h", tag, k, obs_qb[k], 4'(15 - mq[k]));
      end
      assert (obs_w[k] === mw[k]) else begin
        miscompares++;
        $error("[TB] FAIL %s inst%0d wrap observed=%b expected=%b", tag, k, obs_w[k], mw[k]);
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, then check just after the edge.
  task automatic applyStimulus(input logic r, input logic l, input logic [3:0] lv,
                               input logic e, input logic [1:0] m, input logic [3:0] tt,
                               input string tag);
    reset    = r;
    load     = l;
    load_val = lv;
    en       = e;
    mode     = m;
    t        = tt;
    modelStep();
    @(posedge clk);
    #1;
    vectors++;
    checkOutput(tag);
  endtask

  // Spot-check a known literal on instance A, independent of the model.
  task automatic checkLiteral(input string tag, input logic [3:0] exp_q, input logic exp_w);
    assert (q_a === exp_q && wrap_a === exp_w) else begin
      miscompares++;
      $error("[TB] FAIL %s q/wrap observed=%h/%b expected=%h/%b", tag, q_a, wrap_a, exp_q, exp_w);
    end
  endtask

  initial begin
    minit[0] = 5;
    minit[1] = 0;
    mq[0] = 0;  mq[1] = 0;
    mw[0] = 1'b0;  mw[1] = 1'b0;
    mtd = 4'h0;
    @(negedge clk);

    // Reset: instance A comes up at 5 / A, instance B at 0 / F.
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, "reset");
    checkLiteral("reset_lit", 4'h5, 1'b0);

    // Toggle with t=0011 held for three edges, starting from q=0.
    applyStimulus(1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 4'h0, "load0");
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 2'd1, 4'b0011, "toggle1");
    checkLiteral("toggle1_lit", 4'h3, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 2'd1, 4'b0011, "toggle2");
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 2'd1, 4'b0011, "toggle3");
    checkLiteral("toggle3_lit", 4'h3, 1'b0);

    // Count up across the all-ones boundary.
    applyStimulus(1'b0, 1'b1, 4'hE, 1'b0, 2'd0, 4'h0, "loadE");
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 2'd2, 4'hF, "up1");
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 2'd2, 4'hF, "up2");
    checkLiteral("up_wrap_lit", 4'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 2'd2, 4'hF, "up3");
    checkLiteral("up_after_lit", 4'h1, 1'b0);

    // Count down through zero, then load wins over an enabled count.
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 2'd3, 4'h0, "down1");
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 2'd3, 4'h0, "down2");
    checkLiteral("down_wrap_lit", 4'hF, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'h9, 1'b1, 2'd3, 4'h0, "load_prio");
    checkLiteral("load_prio_lit", 4'h9, 1'b0);

    // Hold via en=0 and via mode=HOLD.
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 2'd2, 4'hF, "hold_en");
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 2'd0, 4'hF, "hold_mode");

    // Reset in the middle of counting up from 7, then resume.
    applyStimulus(1'b0, 1'b1, 4'h6, 1'b0, 2'd0, 4'h0, "load6");
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 2'd2, 4'h0, "up_to7");
    applyStimulus(1'b1, 1'b1, 4'hC, 1'b1, 2'd2, 4'h0, "mid_reset");
    assert (q_b === 4'h0 && qb_b === 4'hF && wrap_b === 1'b0) else begin
      miscompares++;
      $error("[TB] FAIL mid_reset_lit q/qb/wrap observed=%h/%h/%b expected=0/f/0", q_b, qb_b, wrap_b);
    end
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 2'd2, 4'h0, "after_reset");
    assert (q_b === 4'h1) else begin
      miscompares++;
      $error("[TB] FAIL after_reset_lit q observed=%h expected=1", q_b);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 24) == 0,
                    $urandom_range(0, 7) == 0,
                    4'($urandom),
                    $urandom_range(0, 5) != 0,
                    2'($urandom),
                    4'($urandom),
                    "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
